// File: rtl/xasted_pkg.sv
// Shared definitions for the shooter-game input stage.
// Contents:
//   db_state_t           - per-key debounce state encoding (2 bits)
//   KEY_HIGH_IDX/LOW_IDX - which KEY bit drives which gun
//   DEBOUNCE_CYCLES_DEF  - default qualification time (10 ms @ 50 MHz)
//   CNT_W_DEF            - default debounce counter width
package xasted_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    DOWN    = 2'd2,
    RELEASE = 2'd3
  } db_state_t;

  localparam int KEY_HIGH_IDX        = 0;
  localparam int KEY_LOW_IDX         = 1;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 20;

endpackage

// File: rtl/key_debounce.sv
// Synchroniser + debounce FSM for one active-low push button.
// Ports:
//   MAX10_CLK1_50  in   system clock
//   rst            in   synchronous active-high reset
//   key_raw        in   raw button, active-low, asynchronous
//   key_down       out  debounced state, 1 = held
//   press          out  1-cycle pulse when a press is accepted
//
// state   | meaning
// IDLE    | released, waiting for a press level
// ARMING  | press level seen, counting stable cycles
// DOWN    | press accepted, waiting for a release level
// RELEASE | release level seen, counting stable cycles
module key_debounce
  import xasted_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic MAX10_CLK1_50,
  input  logic rst,
  input  logic key_raw,
  output logic key_down,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             k;
  db_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             press_nx;

  // Sync flops reset to 1 (released), so a key held through reset
  // has to qualify again from scratch.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      sync  <= 2'b11;
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_raw};
      state <= state_nx;
      cnt   <= cnt_nx;
      press <= press_nx;
    end
  end

  assign k = ~sync[1];

  // Leaving ARMING/RELEASE at the terminal count leaves cnt parked there,
  // so the counter never wraps.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press_nx = 1'b0;
    case (state)
      IDLE: begin
        if (k) begin
          state_nx = ARMING;
          cnt_nx   = '0;
        end
      end
      ARMING: begin
        if (!k) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx = DOWN;
          press_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        if (!k) begin
          state_nx = RELEASE;
          cnt_nx   = '0;
        end
      end
      RELEASE: begin
        if (k) begin
          state_nx = DOWN;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    key_down = (state == DOWN) || (state == RELEASE);
  end

endmodule

// File: rtl/key_event_conditioner.sv
// Input stage for the 7-segment shooter: debounces both KEY buttons and
// turns each accepted press into one latched fire request.
// Ports:
//   MAX10_CLK1_50  in   50 MHz system clock
//   rst            in   synchronous active-high reset
//   KEY[1:0]       in   raw buttons, active-low; KEY[0]=high gun, KEY[1]=low gun
//   consume        in   1-cycle strobe: pending request has been taken
//   fire_high      out  latched high-gun request
//   fire_low       out  latched low-gun request
//   key_down[1:0]  out  debounced key state, 1 = held
//   press_dropped  out  1-cycle pulse when a press could not be latched
module key_event_conditioner
  import xasted_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       MAX10_CLK1_50,
  input  logic       rst,
  input  logic [1:0] KEY,
  input  logic       consume,
  output logic       fire_high,
  output logic       fire_low,
  output logic [1:0] key_down,
  output logic       press_dropped
);

  logic [1:0] press_ev;
  logic       pending_kept;
  logic       fire_high_nx, fire_low_nx, dropped_nx;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_high (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .rst           (rst),
    .key_raw       (KEY[KEY_HIGH_IDX]),
    .key_down      (key_down[KEY_HIGH_IDX]),
    .press         (press_ev[KEY_HIGH_IDX])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_low (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .rst           (rst),
    .key_raw       (KEY[KEY_LOW_IDX]),
    .key_down      (key_down[KEY_LOW_IDX]),
    .press         (press_ev[KEY_LOW_IDX])
  );

  // Consume is applied first, so an event arriving with consume is latched
  // (set wins over clear). Only one request may be pending; high wins a tie.
  always_comb begin
    pending_kept = (fire_high | fire_low) & ~consume;
    fire_high_nx = fire_high & ~consume;
    fire_low_nx  = fire_low & ~consume;
    dropped_nx   = 1'b0;
    if (!pending_kept) begin
      if (press_ev[KEY_HIGH_IDX]) begin
        fire_high_nx = 1'b1;
      end else if (press_ev[KEY_LOW_IDX]) begin
        fire_low_nx = 1'b1;
      end
      dropped_nx = press_ev[KEY_HIGH_IDX] & press_ev[KEY_LOW_IDX];
    end else begin
      dropped_nx = press_ev[KEY_HIGH_IDX] | press_ev[KEY_LOW_IDX];
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      fire_high     <= 1'b0;
      fire_low      <= 1'b0;
      press_dropped <= 1'b0;
    end else begin
      fire_high     <= fire_high_nx;
      fire_low      <= fire_low_nx;
      press_dropped <= dropped_nx;
    end
  end

endmodule

// File: tb/tb_key_event_conditioner.sv
// Bench for key_event_conditioner with DEBOUNCE_CYCLES=4.
// Expected output values are queued with the cycle they must appear in,
// and a monitor compares them as the DUT reaches that cycle.
// Observed vector bits: {press_dropped, key_down[1], key_down[0], fire_low, fire_high}.
module tb_key_event_conditioner;

  localparam logic [4:0] M_ALL = 5'b11111;
  localparam logic [4:0] M_FH  = 5'b00001;
  localparam logic [4:0] M_FL  = 5'b00010;
  localparam logic [4:0] M_KD0 = 5'b00100;
  localparam logic [4:0] M_KD1 = 5'b01000;
  localparam logic [4:0] M_PD  = 5'b10000;

  typedef struct {
    int         cyc;
    string      tag;
    logic [4:0] mask;
    logic [4:0] val;
  } exp_t;

  logic       MAX10_CLK1_50 = 1'b0;
  logic       rst;
  logic [1:0] KEY;
  logic       consume;
  logic       fire_high, fire_low, press_dropped;
  logic [1:0] key_down;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_n    = 0;
  exp_t sb_q[$];

  key_event_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .rst           (rst),
    .KEY           (KEY),
    .consume       (consume),
    .fire_high     (fire_high),
    .fire_low      (fire_low),
    .key_down      (key_down),
    .press_dropped (press_dropped)
  );

  always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %b want %b", tag, cyc_n, obs[4:0], exp_v[4:0]);
    end
  endtask

  // Queue expectations for cycles cyc_n+a .. cyc_n+b.
  task automatic expect_rng(input int a, input int b, input string tag,
                            input logic [4:0] m, input logic [4:0] v);
    exp_t e;
    for (int c = a; c <= b; c++) begin
      e.cyc  = cyc_n + c;
      e.tag  = tag;
      e.mask = m;
      e.val  = v;
      sb_q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge MAX10_CLK1_50);
    #2;
  endtask

  always @(posedge MAX10_CLK1_50) begin
    logic [4:0] obs;
    cyc_n++;
    #1;
    obs = {press_dropped, key_down, fire_low, fire_high};
    check_val("excl", int'(fire_high & fire_low), 0);
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc_n) begin
        check_val(sb_q[i].tag, int'(obs & sb_q[i].mask), int'(sb_q[i].val & sb_q[i].mask));
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    KEY     = 2'b11;
    consume = 1'b0;

    // reset and idle after release
    expect_rng(1, 3, "rst_hold", M_ALL, 5'b0);
    step(3);
    rst = 1'b0;
    expect_rng(1, 8, "post_rst_idle", M_ALL, 5'b0);
    step(8);

    // clean high press held 20 cycles
    KEY[0] = 1'b0;
    expect_rng(6, 6, "t2_kd0_early", M_KD0 | M_FH, 5'b0);
    expect_rng(7, 7, "t2_kd0_set", M_KD0 | M_FH, M_KD0);
    expect_rng(8, 8, "t2_fh_set", M_ALL, M_KD0 | M_FH);
    expect_rng(9, 20, "t2_fh_hold", M_ALL, M_KD0 | M_FH);
    step(20);
    KEY[0]  = 1'b1;
    consume = 1'b1;
    expect_rng(1, 1, "t2_consume", M_FH | M_KD0, M_KD0);
    step(1);
    consume = 1'b0;
    expect_rng(5, 5, "t2_kd0_held", M_KD0, M_KD0);
    expect_rng(6, 9, "t2_released", M_ALL, 5'b0);
    step(9);

    // bouncing low key
    expect_rng(1, 4, "t3_bounce", M_ALL, 5'b0);
    KEY[1] = 1'b0; step(1);
    KEY[1] = 1'b1; step(1);
    KEY[1] = 1'b0; step(1);
    KEY[1] = 1'b1; step(1);
    KEY[1] = 1'b0;
    expect_rng(1, 6, "t3_qual", M_ALL, 5'b0);
    expect_rng(7, 7, "t3_kd1", M_ALL, M_KD1);
    expect_rng(8, 8, "t3_fl", M_ALL, M_KD1 | M_FL);
    expect_rng(9, 15, "t3_single", M_ALL, M_KD1 | M_FL);
    step(15);
    consume = 1'b1;
    KEY[1]  = 1'b1;
    expect_rng(1, 1, "t3_consume", M_FL | M_FH, 5'b0);
    step(1);
    consume = 1'b0;
    expect_rng(1, 8, "t3_release", M_FL | M_FH | M_PD, 5'b0);
    expect_rng(6, 8, "t3_kd1_off", M_KD1, 5'b0);
    step(8);

    // both keys on the same cycle
    KEY = 2'b00;
    expect_rng(7, 7, "t4_pre", M_ALL, M_KD0 | M_KD1);
    expect_rng(8, 8, "t4_both", M_ALL, M_KD0 | M_KD1 | M_FH | M_PD);
    expect_rng(9, 12, "t4_after", M_ALL, M_KD0 | M_KD1 | M_FH);
    step(12);

    // low press while high pending
    KEY[1] = 1'b1;
    expect_rng(1, 8, "t5_rel", M_FH | M_FL | M_PD, M_FH);
    step(8);
    KEY[1] = 1'b0;
    expect_rng(7, 7, "t5_pre", M_ALL, M_KD0 | M_KD1 | M_FH);
    expect_rng(8, 8, "t5_drop", M_ALL, M_KD0 | M_KD1 | M_FH | M_PD);
    expect_rng(9, 11, "t5_after", M_ALL, M_KD0 | M_KD1 | M_FH);
    step(11);
    consume = 1'b1;
    expect_rng(1, 1, "t5_consume", M_ALL, M_KD0 | M_KD1);
    step(1);
    consume = 1'b0;
    expect_rng(1, 3, "t5_idle", M_ALL, M_KD0 | M_KD1);
    step(3);
    KEY = 2'b11;
    expect_rng(7, 9, "t5_rel_all", M_ALL, 5'b0);
    step(9);

    // consume on the exact cycle a low event fires
    KEY[0] = 1'b0;
    expect_rng(8, 8, "t6_fh", M_FH | M_FL, M_FH);
    step(9);
    KEY[0] = 1'b1;
    expect_rng(7, 8, "t6_fh_pend", M_ALL, M_FH);
    step(8);
    KEY[1] = 1'b0;
    expect_rng(7, 7, "t6_pre", M_ALL, M_KD1 | M_FH);
    step(7);
    consume = 1'b1;
    expect_rng(1, 1, "t6_set_wins", M_ALL, M_KD1 | M_FL);
    step(1);
    consume = 1'b0;
    expect_rng(1, 3, "t6_fl_hold", M_ALL, M_KD1 | M_FL);
    step(3);

    // reset while fire_low pending and KEY[1] still held
    rst = 1'b1;
    expect_rng(1, 1, "t7_rst", M_ALL, 5'b0);
    step(1);
    rst = 1'b0;
    expect_rng(1, 6, "t7_requal", M_ALL, 5'b0);
    expect_rng(7, 7, "t7_kd1", M_ALL, M_KD1);
    expect_rng(8, 8, "t7_fl", M_ALL, M_KD1 | M_FL);
    step(10);

    consume = 1'b1;
    KEY     = 2'b11;
    step(1);
    consume = 1'b0;
    step(3);
    check_val("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
